// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with oversampled mid-bit sampling,
// a one-cycle done strobe per byte and a one-cycle framing-error strobe.
module uart_rx #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int oversample = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       donerx,
  output logic       frame_err,
  output logic       busy
);
  localparam int div = clk_freq / (baud_rate * oversample);
  localparam int tw  = div > 1 ? $clog2(div) : 1;
  localparam int sw  = $clog2(oversample);

  if (div < 1 || oversample < 4 || oversample % 2 != 0) begin : g_bad_params
    $error("uart_rx: need div >= 1 and an even oversample >= 4");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [tw-1:0]   tick_cnt_q, tick_cnt_d;
  logic [sw-1:0]   s_cnt_q, s_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_s, tick, half_hit, full_hit;

  assign rx_s     = sync2_q;
  assign tick     = tick_cnt_q == tw'(div - 1);
  assign half_hit = s_cnt_q == sw'(oversample / 2 - 1);
  assign full_hit = s_cnt_q == sw'(oversample - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_cnt_q <= '0;
      s_cnt_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      s_cnt_q    <= s_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  // Tick phase is held while waiting so sampling aligns to the start edge.
  always_comb tick_cnt_d = (state_q == IDLE || state_q == WAIT_HIGH || tick) ? '0 : tick_cnt_q + tw'(1);

  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          s_cnt_d = s_cnt_q + sw'(1);
          if (half_hit) begin
            state_d   = rx_s ? IDLE : DATA;
            s_cnt_d   = '0;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          s_cnt_d = s_cnt_q + sw'(1);
          if (full_hit) begin
            shift_d[bit_idx_q] = rx_s;
            s_cnt_d            = '0;
            bit_idx_d          = bit_idx_q + 3'd1;
            state_d            = bit_idx_q == 3'd7 ? STOP : DATA;
          end
        end
      end
      STOP: begin
        if (tick) begin
          s_cnt_d = s_cnt_q + sw'(1);
          if (full_hit) begin
            s_cnt_d = '0;
            data_d  = rx_s ? shift_q : data_q;
            done_d  = rx_s;
            ferr_d  = !rx_s;
            state_d = rx_s ? IDLE : WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = state_q != IDLE;
    rx_data   = data_q;
    donerx    = done_q;
    frame_err = ferr_q;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive stage directly downstream of the UART transmitter.
- Recovers 8N1 frames from the serial line (idle high, one start bit low, 8 data bits LSB-first, one stop bit high) using 16x-style oversampling off the single system clock.
- Presents each received byte with a one-cycle done strobe.
- Flags framing errors for the consuming logic.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, line bit rate in bits/s.
- oversample, 16, ticks per bit; must be even and >= 4.
- Derived constant div = clk_freq/(baud_rate*oversample), integer division, must be >= 1. Elaboration-time error if div < 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk.
- rx_data  output  8  last correctly received byte.
- donerx  output  1  one-cycle pulse: rx_data updated with a new byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset (rst low, asynchronous):
  - Reset values: rx_data=8'h00, donerx=0, frame_err=0, busy=0.
  - Internal state: state=IDLE, counters=0, both synchronizer flops=1.
  - Reset asserted mid-frame aborts the frame silently, with no strobes.
- Input sync: rx passes through a 2-flop synchronizer; rx_s is the second flop. All decisions use rx_s only (2-cycle input latency).
- Tick generator:
  - tick_cnt counts 0..div-1; tick is high for one clk when tick_cnt==div-1, after which tick_cnt wraps to 0.
  - tick_cnt is held at 0 in IDLE and in WAIT_HIGH, so the sampling phase aligns to the detected start edge.
- Counters: s_cnt (0..oversample-1) counts ticks within a bit; bit_idx (0..7) selects the data bit.
- States:
  - IDLE: busy=0. On rx_s==0, go to START and clear s_cnt.
  - START: on each tick, s_cnt++. When s_cnt reaches oversample/2-1 on a tick (mid start bit):
    - rx_s==0: clear s_cnt and bit_idx, go to DATA.
    - rx_s==1: glitch; return to IDLE with no strobe.
  - DATA: on each tick, s_cnt++. When s_cnt==oversample-1 on a tick (mid data bit):
    - Shift rx_s into shift register bit position bit_idx (LSB first) and clear s_cnt.
    - If bit_idx==7, go to STOP; else bit_idx++.
  - STOP: on each tick, s_cnt++. When s_cnt==oversample-1 on a tick (mid stop bit):
    - rx_s==1: rx_data <= shift register, donerx=1 for the next clk only, go to IDLE.
    - rx_s==0: frame_err=1 for the next clk only, rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: busy=1. Stay until rx_s==1, then go to IDLE. A held-low break line therefore produces exactly one frame_err and no re-triggering.
- Timing and boundary rules:
  - Latency from the start-bit falling edge on rx to the donerx pulse is about 9.5 bit periods, plus 2-3 clk of synchronizer and registering.
  - Back-to-back frames are accepted: IDLE is re-entered at mid stop bit, so the next start edge is detected with no dead time.
  - donerx and frame_err are never high in the same cycle.
  - rx_data holds its value between frames.
  - An rx glitch shorter than half a bit at frame start is rejected.
  - No FIFO: the consumer must capture rx_data on donerx; an overwrite by the next frame is not flagged.

Test Plan:
(Bench parameters: clk_freq=1600000, baud_rate=10000, oversample=16, so div=10 and one bit = 160 clk.)
- Reset: hold rst=0 for 5 clk with rx=1 -> rx_data=8'h00, donerx=0, frame_err=0, busy=0; release -> outputs unchanged while rx idles high.
- Single frame: drive 8'hA5 (start, 1,0,1,0,0,1,0,1, stop) at 160 clk/bit -> exactly one donerx pulse, rx_data=8'hA5 about 1520 clk after the start edge, busy=0 afterward, frame_err never high.
- Back-to-back: frames 8'h00, 8'hFF, 8'h3C with no idle gap -> three donerx pulses spaced 1600 clk apart, rx_data showing each value in order.
- Framing error: send 8'h55 with stop bit driven 0, then hold rx low for 500 clk before returning high -> one frame_err pulse, rx_data keeps its previous value, no donerx, busy=1 until rx_s returns high, then the next valid 8'h12 frame is received correctly.
- Glitch rejection: drive rx low for 40 clk, then high -> state returns to IDLE, no donerx or frame_err, busy drops within 100 clk.
- Async reset mid-frame: send 8'hC3 and assert rst=0 for 3 clk during bit 4 -> outputs reset immediately with no strobe; a following 8'h81 frame yields donerx with rx_data=8'h81.
